// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding,
// trap cause codes and the reset value of the instruction register.
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [2:0] CAUSE_ILLEGAL  = 3'd0;
  localparam logic [2:0] CAUSE_SYSTEM   = 3'd1;
  localparam logic [2:0] CAUSE_IMEM_TO  = 3'd2;
  localparam logic [2:0] CAUSE_DMEM_TO  = 3'd3;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd4;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // A control-transfer target is only legal on a word boundary.
  function automatic logic isMisaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshakes of the core sequencer.
// The sequencer is the master on both buses; memories are slaves.
interface core_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/bus_timer.sv
// Wait-cycle counter shared by the instruction fetch and the data access.
// 'expired' flags the request cycle in which the wait budget runs out
// without an acknowledge; an ack in that same cycle deasserts 'run' and
// so suppresses it.
module bus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic nreset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [7:0] r_count;

  // Count unacknowledged request cycles; any idle or acked cycle restarts.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = run && (r_count == 8'(LIMIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer. Owns the PC and the instruction
// register, drives both memory handshakes, turns decoder flags into
// single-cycle ALU / register-file / retire strobes and parks in a sticky
// TRAP state on any fault until the next reset.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BUS_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               stall,
  core_sequencer_if.master   bus,
  output logic [31:0]        ir,
  output logic               dec_nreset,
  input  logic               mem_en,
  input  logic               rw,
  input  logic               rd_enc,
  input  logic               is_jal,
  input  logic               is_jalr,
  input  logic               is_branch,
  input  logic               is_fence,
  input  logic               is_system,
  input  logic               is_invalid,
  input  logic               branch_taken,
  input  logic [31:0]        target,
  output logic               exec_en,
  output logic               rf_we,
  output logic [31:0]        pc,
  output logic               retire,
  output logic               trap,
  output logic [2:0]         trap_cause
);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [2:0]  r_cause;
  logic [2:0]  w_nextCause;
  logic        r_fetchPending;
  logic        w_loadIr;
  logic        w_loadPc;
  logic [31:0] w_nextPc;
  logic        w_busReq;
  logic        w_busAck;
  logic        w_expired;

  assign w_nextPc = (is_jal || is_jalr || (is_branch && branch_taken)) ? target : r_pc + 32'd4;

  assign w_busReq = bus.imem_req || bus.dmem_req;
  assign w_busAck = (bus.imem_req && bus.imem_ack) || (bus.dmem_req && bus.dmem_ack);

  bus_timer #(
    .LIMIT(BUS_TIMEOUT)
  ) u_busTimer (
    .clk    (clk),
    .nreset (nreset),
    .run    (w_busReq && !w_busAck),
    .clear  (!w_busReq || w_busAck),
    .expired(w_expired)
  );

  // State, PC, instruction register and trap cause registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_ir           <= NOP_INST;
      r_cause        <= CAUSE_ILLEGAL;
      r_fetchPending <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_cause        <= w_nextCause;
      r_fetchPending <= bus.imem_req && !bus.imem_ack && (w_nextState == S_FETCH);
      if (w_loadIr) begin
        r_ir <= bus.imem_rdata;
      end
      if (w_loadPc) begin
        r_pc <= w_nextPc;
      end
    end
  end

  // Next-state selection and per-state strobes; the fetch request is gated
  // by reset so nothing is requested while reset is held.
  always_comb begin
    w_nextState  = r_state;
    w_nextCause  = r_cause;
    w_loadIr     = 1'b0;
    w_loadPc     = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    exec_en      = 1'b0;
    rf_we        = 1'b0;
    retire       = 1'b0;
    dec_nreset   = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.imem_req = nreset && (r_fetchPending || !stall);
        if (bus.imem_req && bus.imem_ack) begin
          w_loadIr    = 1'b1;
          w_nextState = S_DECODE;
        end else if (w_expired) begin
          w_nextCause = CAUSE_IMEM_TO;
          w_nextState = S_TRAP;
        end
      end
      S_DECODE: begin
        dec_nreset = 1'b1;
        if (is_invalid) begin
          w_nextCause = CAUSE_ILLEGAL;
          w_nextState = S_TRAP;
        end else if (is_system) begin
          w_nextCause = CAUSE_SYSTEM;
          w_nextState = S_TRAP;
        end else if (is_fence) begin
          w_nextState = S_WB;
        end else begin
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        dec_nreset  = 1'b1;
        exec_en     = 1'b1;
        w_nextState = mem_en ? S_MEM : S_WB;
      end
      S_MEM: begin
        dec_nreset   = 1'b1;
        bus.dmem_req = 1'b1;
        bus.dmem_we  = rw;
        if (bus.dmem_ack) begin
          w_nextState = S_WB;
        end else if (w_expired) begin
          w_nextCause = CAUSE_DMEM_TO;
          w_nextState = S_TRAP;
        end
      end
      S_WB: begin
        dec_nreset = 1'b1;
        rf_we      = rd_enc;
        retire     = 1'b1;
        if (isMisaligned(w_nextPc)) begin
          w_nextCause = CAUSE_MISALIGN;
          w_nextState = S_TRAP;
        end else begin
          w_loadPc    = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_TRAP: begin
        w_nextState = S_TRAP;
      end
      default: begin
        w_nextState = S_FETCH;
      end
    endcase
  end

  assign bus.imem_addr = r_pc;
  assign pc            = r_pc;
  assign ir            = r_ir;
  assign trap          = (r_state == S_TRAP);
  assign trap_cause    = r_cause;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. The bench plays both memories
// and the decoder; a latency/next-PC model derived from the instruction
// class predicts every observation.
module tb_core_sequencer;
  import core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          TMO    = 4;

  typedef struct {
    bit          memEn, rw, rdEnc, jal, jalr, branch, taken, fence, system, invalid;
    bit          stallMid, resetInMem;
    logic [31:0] target, inst;
    int          iWait, dWait;
  } instr_t;

  typedef struct {
    logic [31:0] fetchAddr, pcAfter, rstPc;
    int          reqCycles, dmemCycles, execCycle, execCount, retireCycle, retireCount;
    bit          rfWe, trap, weBad, rstReq, timedOut;
    logic [2:0]  cause;
  } obs_t;

  logic        clk, nreset, stall;
  logic        mem_en, rw, rd_enc, is_jal, is_jalr, is_branch, is_fence, is_system, is_invalid;
  logic        branch_taken;
  logic [31:0] target;
  logic [31:0] ir, pc;
  logic        dec_nreset, exec_en, rf_we, retire, trap;
  logic [2:0]  trap_cause;

  int          vectors;
  int          miscompares;
  logic [31:0] modelPc;

  core_sequencer_if bus();

  core_sequencer #(
    .RESET_PC   (RST_PC),
    .BUS_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .stall       (stall),
    .bus         (bus),
    .ir          (ir),
    .dec_nreset  (dec_nreset),
    .mem_en      (mem_en),
    .rw          (rw),
    .rd_enc      (rd_enc),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .is_branch   (is_branch),
    .is_fence    (is_fence),
    .is_system   (is_system),
    .is_invalid  (is_invalid),
    .branch_taken(branch_taken),
    .target      (target),
    .exec_en     (exec_en),
    .rf_we       (rf_we),
    .pc          (pc),
    .retire      (retire),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic instr_t blankInstr();
    instr_t t;
    t = '{default: 0};
    t.inst = NOP_INST;
    return t;
  endfunction

  // Expected behaviour from the instruction class: cycle counts are laid out
  // as fetch wait, one decode cycle, one execute cycle, data wait, write-back.
  function automatic obs_t model(input instr_t t, input logic [31:0] pcIn);
    obs_t        e;
    int          c;
    logic [31:0] nxt;
    e = '{default: 0};
    e.fetchAddr = pcIn;
    e.pcAfter   = pcIn;
    if (t.iWait < 0 || t.iWait >= TMO) begin
      e.reqCycles = TMO; e.trap = 1; e.cause = 3'd2;
      return e;
    end
    e.reqCycles = t.iWait + 1;
    c = e.reqCycles + 1;
    if (t.invalid) begin e.trap = 1; e.cause = 3'd0; return e; end
    if (t.system)  begin e.trap = 1; e.cause = 3'd1; return e; end
    if (!t.fence) begin
      c++;
      e.execCycle = c;
      e.execCount = 1;
      if (t.memEn) begin
        if (t.dWait < 0 || t.dWait >= TMO) begin
          e.dmemCycles = TMO; e.trap = 1; e.cause = 3'd3;
          return e;
        end
        e.dmemCycles = t.dWait + 1;
        c += e.dmemCycles;
      end
    end
    c++;
    e.retireCycle = c;
    e.retireCount = 1;
    e.rfWe        = t.rdEnc;
    nxt = (t.jal || t.jalr || (t.branch && t.taken)) ? t.target : pcIn + 32'd4;
    if (nxt[1:0] != 2'b00) begin
      e.trap = 1; e.cause = 3'd4;
    end else begin
      e.pcAfter = nxt;
    end
    return e;
  endfunction

  // Plays decoder and memories for one instruction starting at a FETCH cycle.
  task automatic execInstr(input instr_t t, output obs_t o);
    int c, iReq, dReq;
    bit done;
    c = 0; iReq = 0; dReq = 0; done = 0;
    o = '{default: 0};
    mem_en = t.memEn; rw = t.rw; rd_enc = t.rdEnc;
    is_jal = t.jal; is_jalr = t.jalr; is_branch = t.branch; branch_taken = t.taken;
    is_fence = t.fence; is_system = t.system; is_invalid = t.invalid;
    target = t.target; bus.imem_rdata = t.inst;
    while (!done) begin
      @(negedge clk);
      c++;
      if (bus.imem_req === 1'b1) begin
        iReq++;
        if (iReq == 1) o.fetchAddr = bus.imem_addr;
      end
      if (exec_en === 1'b1) begin o.execCycle = c; o.execCount++; end
      if (bus.dmem_req === 1'b1) begin
        dReq++;
        if (bus.dmem_we !== t.rw) o.weBad = 1;
      end
      bus.imem_ack = (bus.imem_req === 1'b1) && (iReq == t.iWait + 1);
      bus.dmem_ack = (bus.dmem_req === 1'b1) && (dReq == t.dWait + 1);
      if (retire === 1'b1) begin
        o.retireCycle = c; o.retireCount++; o.rfWe = rf_we;
      end
      if (trap === 1'b1) begin
        o.trap = 1; o.cause = trap_cause; done = 1;
      end else if (retire === 1'b1) begin
        @(posedge clk); #1;
        o.pcAfter = pc; o.trap = trap; o.cause = trap_cause; done = 1;
      end else if (t.resetInMem && dReq == 2) begin
        nreset = 1'b0; #1;
        o.rstReq = bus.dmem_req; o.rstPc = pc;
        @(posedge clk); #1;
        nreset = 1'b1; done = 1;
      end else if (t.stallMid && iReq == 1 && !bus.imem_ack) begin
        @(posedge clk); #1;
        stall = 1'b1;
      end
      if (!done && c >= 60) begin o.timedOut = 1; done = 1; end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    stall        = 1'b0;
    o.reqCycles  = iReq;
    o.dmemCycles = dReq;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    modelPc = RST_PC;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (pc !== RST_PC) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RST_PC); end
    vectors++; if (ir !== 32'h13) begin miscompares++; $display("[TB] FAIL reset_ir: got %h expected %h", ir, 32'h13); end
    vectors++; if ({trap, trap_cause} !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_trap: got %b expected 0000", {trap, trap_cause}); end
    vectors++; if ({exec_en, rf_we, retire, bus.dmem_req, bus.imem_req, dec_nreset} !== 6'b0) begin miscompares++; $display("[TB] FAIL reset_strobes: got %b expected 000000", {exec_en, rf_we, retire, bus.dmem_req, bus.imem_req, dec_nreset}); end
    @(posedge clk); #1;
    nreset = 1'b1;
    modelPc = RST_PC;
  endtask

  task automatic test_fetch();
    instr_t t; obs_t o;
    t = blankInstr(); t.rdEnc = 1; t.inst = 32'h00500093;
    execInstr(t, o);
    vectors++; if (o.fetchAddr !== 32'h100) begin miscompares++; $display("[TB] FAIL fetch_addr: got %h expected %h", o.fetchAddr, 32'h100); end
    vectors++; if (o.execCycle !== 3) begin miscompares++; $display("[TB] FAIL fetch_exec_cycle: got %0d expected 3", o.execCycle); end
    vectors++; if (o.retireCycle !== 4) begin miscompares++; $display("[TB] FAIL fetch_retire_cycle: got %0d expected 4", o.retireCycle); end
    vectors++; if (o.rfWe !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_rf_we: got %b expected 1", o.rfWe); end
    vectors++; if (ir !== 32'h00500093) begin miscompares++; $display("[TB] FAIL fetch_ir: got %h expected %h", ir, 32'h00500093); end
    modelPc = o.pcAfter;
    execInstr(t, o);
    vectors++; if (o.fetchAddr !== 32'h104) begin miscompares++; $display("[TB] FAIL fetch_next_addr: got %h expected %h", o.fetchAddr, 32'h104); end
    modelPc = 32'h108;
    vectors++; if (pc !== modelPc) begin miscompares++; $display("[TB] FAIL fetch_pc_after: got %h expected %h", pc, modelPc); end
  endtask

  task automatic test_load();
    instr_t t; obs_t o;
    t = blankInstr(); t.memEn = 1; t.rdEnc = 1; t.dWait = 3; t.inst = 32'h0000a103;
    execInstr(t, o);
    vectors++; if (o.dmemCycles !== 4) begin miscompares++; $display("[TB] FAIL load_dmem_cycles: got %0d expected 4", o.dmemCycles); end
    vectors++; if (o.weBad !== 1'b0) begin miscompares++; $display("[TB] FAIL load_dmem_we: got %b expected 0", o.weBad); end
    vectors++; if (o.retireCycle !== 8) begin miscompares++; $display("[TB] FAIL load_latency: got %0d expected 8", o.retireCycle); end
    vectors++; if (o.rfWe !== 1'b1) begin miscompares++; $display("[TB] FAIL load_rf_we: got %b expected 1", o.rfWe); end
    modelPc = modelPc + 32'd4;
  endtask

  task automatic test_branch();
    instr_t t; obs_t o; logic [31:0] startPc;
    t = blankInstr(); t.branch = 1; t.taken = 1; t.target = 32'h200; t.inst = 32'h00208063;
    execInstr(t, o);
    vectors++; if (o.rfWe !== 1'b0) begin miscompares++; $display("[TB] FAIL branch_rf_we: got %b expected 0", o.rfWe); end
    vectors++; if (o.pcAfter !== 32'h200) begin miscompares++; $display("[TB] FAIL branch_taken_pc: got %h expected %h", o.pcAfter, 32'h200); end
    modelPc = 32'h200;
    t.taken = 0;
    execInstr(t, o);
    startPc = o.fetchAddr;
    execInstr(blankInstr(), o);
    vectors++; if (o.fetchAddr !== 32'h204) begin miscompares++; $display("[TB] FAIL branch_not_taken_addr: got %h expected %h (from %h)", o.fetchAddr, 32'h204, startPc); end
    modelPc = 32'h208;
  endtask

  task automatic test_random();
    instr_t t; obs_t o, e;
    for (int i = 0; i < 24; i++) begin
      t = blankInstr();
      t.iWait    = int'($urandom_range(0, 3));
      t.dWait    = int'($urandom_range(0, 3));
      t.target   = $urandom & 32'h0000_fffc;
      t.stallMid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: begin t.rdEnc = 1; t.inst = 32'h00208133; end
        1: begin t.memEn = 1; t.rdEnc = 1; t.inst = 32'h0000a183; end
        2: begin t.memEn = 1; t.rw = 1; t.inst = 32'h0020a023; end
        3: begin t.jal = 1'($urandom_range(0, 1)); t.jalr = !t.jal; t.rdEnc = 1; t.inst = 32'h0000006f; end
        4: begin t.branch = 1; t.taken = 1'($urandom_range(0, 1)); t.inst = 32'h00208063; end
        default: begin t.fence = 1; t.rdEnc = 1'($urandom_range(0, 1)); t.inst = 32'h0000000f; end
      endcase
      e = model(t, modelPc);
      execInstr(t, o);
      vectors++; if (o.timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL rand%0d_budget: got %b expected 0", i, o.timedOut); end
      vectors++; if (o.fetchAddr !== e.fetchAddr) begin miscompares++; $display("[TB] FAIL rand%0d_fetch_addr: got %h expected %h", i, o.fetchAddr, e.fetchAddr); end
      vectors++; if (o.reqCycles !== e.reqCycles) begin miscompares++; $display("[TB] FAIL rand%0d_req_cycles: got %0d expected %0d", i, o.reqCycles, e.reqCycles); end
      vectors++; if (o.execCycle !== e.execCycle || o.execCount !== e.execCount) begin miscompares++; $display("[TB] FAIL rand%0d_exec: got cycle %0d count %0d expected cycle %0d count %0d", i, o.execCycle, o.execCount, e.execCycle, e.execCount); end
      vectors++; if (o.dmemCycles !== e.dmemCycles || o.weBad !== 1'b0) begin miscompares++; $display("[TB] FAIL rand%0d_dmem: got %0d cycles we_bad %b expected %0d cycles we_bad 0", i, o.dmemCycles, o.weBad, e.dmemCycles); end
      vectors++; if (o.retireCycle !== e.retireCycle || o.retireCount !== e.retireCount) begin miscompares++; $display("[TB] FAIL rand%0d_retire: got cycle %0d count %0d expected cycle %0d count %0d", i, o.retireCycle, o.retireCount, e.retireCycle, e.retireCount); end
      vectors++; if (o.rfWe !== e.rfWe) begin miscompares++; $display("[TB] FAIL rand%0d_rf_we: got %b expected %b", i, o.rfWe, e.rfWe); end
      vectors++; if (o.pcAfter !== e.pcAfter || o.trap !== e.trap) begin miscompares++; $display("[TB] FAIL rand%0d_pc: got %h trap %b expected %h trap %b", i, o.pcAfter, o.trap, e.pcAfter, e.trap); end
      modelPc = e.pcAfter;
    end
  endtask

  task automatic test_stall();
    instr_t t; obs_t o, e;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_idle_req%0d: got %b expected 0", i, bus.imem_req); end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    t = blankInstr(); t.rdEnc = 1; t.iWait = 2; t.stallMid = 1; t.inst = 32'h00100093;
    e = model(t, modelPc);
    execInstr(t, o);
    vectors++; if (o.reqCycles !== e.reqCycles || o.timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_mid_req: got %0d cycles timeout %b expected %0d cycles", o.reqCycles, o.timedOut, e.reqCycles); end
    vectors++; if (o.retireCycle !== e.retireCycle || o.pcAfter !== e.pcAfter) begin miscompares++; $display("[TB] FAIL stall_mid_retire: got cycle %0d pc %h expected cycle %0d pc %h", o.retireCycle, o.pcAfter, e.retireCycle, e.pcAfter); end
    modelPc = e.pcAfter;
  endtask

  task automatic test_reset_mem();
    instr_t t; obs_t o;
    t = blankInstr(); t.memEn = 1; t.rw = 1; t.dWait = -1; t.resetInMem = 1; t.inst = 32'h0020a023;
    execInstr(t, o);
    vectors++; if (o.rstReq !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmem_dmem_req: got %b expected 0", o.rstReq); end
    vectors++; if (o.rstPc !== RST_PC) begin miscompares++; $display("[TB] FAIL rstmem_pc: got %h expected %h", o.rstPc, RST_PC); end
    modelPc = RST_PC;
    t = blankInstr(); t.rdEnc = 1;
    execInstr(t, o);
    vectors++; if (o.fetchAddr !== RST_PC || o.retireCycle !== 4) begin miscompares++; $display("[TB] FAIL rstmem_refetch: got %h at retire %0d expected %h at retire 4", o.fetchAddr, o.retireCycle, RST_PC); end
    modelPc = RST_PC + 32'd4;
  endtask

  task automatic test_timeout();
    instr_t t; obs_t o;
    t = blankInstr(); t.iWait = -1;
    execInstr(t, o);
    vectors++; if (o.trap !== 1'b1 || o.cause !== 3'd2) begin miscompares++; $display("[TB] FAIL tmo_imem_trap: got trap %b cause %0d expected trap 1 cause 2", o.trap, o.cause); end
    vectors++; if (o.reqCycles !== TMO) begin miscompares++; $display("[TB] FAIL tmo_imem_cycles: got %0d expected %0d", o.reqCycles, TMO); end
    pulseReset();
    t = blankInstr(); t.iWait = TMO - 1; t.rdEnc = 1;
    execInstr(t, o);
    vectors++; if (o.trap !== 1'b0 || o.retireCycle !== TMO + 3) begin miscompares++; $display("[TB] FAIL tmo_ack_wins: got trap %b retire %0d expected trap 0 retire %0d", o.trap, o.retireCycle, TMO + 3); end
    modelPc = RST_PC + 32'd4;
    t = blankInstr(); t.memEn = 1; t.dWait = -1;
    execInstr(t, o);
    vectors++; if (o.trap !== 1'b1 || o.cause !== 3'd3 || o.dmemCycles !== TMO) begin miscompares++; $display("[TB] FAIL tmo_dmem: got trap %b cause %0d cycles %0d expected trap 1 cause 3 cycles %0d", o.trap, o.cause, o.dmemCycles, TMO); end
    vectors++; if (pc !== modelPc) begin miscompares++; $display("[TB] FAIL tmo_dmem_pc: got %h expected %h", pc, modelPc); end
    pulseReset();
  endtask

  task automatic test_illegal_system();
    instr_t t; obs_t o; int reqs;
    for (int k = 0; k < 2; k++) begin
      t = blankInstr();
      if (k == 0) begin t.invalid = 1; t.inst = 32'h0000007f; end
      else begin t.system = 1; t.inst = 32'h00000073; end
      execInstr(t, o);
      vectors++; if (o.trap !== 1'b1 || o.cause !== 3'(k)) begin miscompares++; $display("[TB] FAIL trap%0d_cause: got trap %b cause %0d expected trap 1 cause %0d", k, o.trap, o.cause, k); end
      vectors++; if (pc !== modelPc || o.execCount !== 0) begin miscompares++; $display("[TB] FAIL trap%0d_pc: got %h exec %0d expected %h exec 0", k, pc, o.execCount, modelPc); end
      reqs = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.imem_req !== 1'b0 || trap !== 1'b1) reqs++;
      end
      vectors++; if (reqs !== 0) begin miscompares++; $display("[TB] FAIL trap%0d_sticky: got %0d active cycles expected 0", k, reqs); end
      pulseReset();
    end
  endtask

  task automatic test_misaligned();
    instr_t t; obs_t o, e;
    t = blankInstr(); t.jalr = 1; t.rdEnc = 1; t.target = 32'h302; t.inst = 32'h00008067;
    e = model(t, modelPc);
    execInstr(t, o);
    vectors++; if (o.trap !== 1'b1 || o.cause !== 3'd4) begin miscompares++; $display("[TB] FAIL misalign_trap: got trap %b cause %0d expected trap 1 cause 4", o.trap, o.cause); end
    vectors++; if (o.rfWe !== 1'b1 || o.retireCycle !== e.retireCycle) begin miscompares++; $display("[TB] FAIL misalign_retire: got rf_we %b retire %0d expected rf_we 1 retire %0d", o.rfWe, o.retireCycle, e.retireCycle); end
    vectors++; if (o.pcAfter !== e.pcAfter) begin miscompares++; $display("[TB] FAIL misalign_pc: got %h expected %h", o.pcAfter, e.pcAfter); end
    pulseReset();
  endtask

  initial begin
    vectors = 0; miscompares = 0; modelPc = RST_PC;
    nreset = 1'b0; stall = 1'b0;
    mem_en = 1'b0; rw = 1'b0; rd_enc = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    is_branch = 1'b0; is_fence = 1'b0; is_system = 1'b0; is_invalid = 1'b0;
    branch_taken = 1'b0; target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = NOP_INST; bus.dmem_ack = 1'b0;
    test_reset();
    test_fetch();
    test_load();
    test_branch();
    test_random();
    test_stall();
    test_reset_mem();
    test_timeout();
    test_illegal_system();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
